// File: rtl/alu_cmd_sequencer.sv
// Collects operand A, operand B and opcode from a word stream, drives the ALU
// and returns its result over a valid/ready handshake.
module alu_cmd_sequencer #(
    parameter int NB_DATA     = 8,
    parameter int NB_OPERADOR = 6
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic [NB_DATA-1:0]     i_rx_data,
    input  logic                   i_rx_valid,
    output logic [NB_DATA-1:0]     o_dato_a,
    output logic [NB_DATA-1:0]     o_dato_b,
    output logic [NB_OPERADOR-1:0] o_operador,
    input  logic [NB_DATA-1:0]     i_resultado,
    output logic [NB_DATA-1:0]     o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic                   o_busy,
    output logic                   o_error
);

    if (NB_DATA < NB_OPERADOR) begin : g_width_check
        $error("NB_DATA must be at least NB_OPERADOR");
    end

    typedef logic [NB_OPERADOR-1:0] op_t;

    localparam op_t OP_ADD = op_t'(6'b100000);
    localparam op_t OP_SUB = op_t'(6'b100010);
    localparam op_t OP_AND = op_t'(6'b100100);
    localparam op_t OP_OR  = op_t'(6'b100101);
    localparam op_t OP_XOR = op_t'(6'b100110);
    localparam op_t OP_NOR = op_t'(6'b100111);
    localparam op_t OP_SRA = op_t'(6'b000011);
    localparam op_t OP_SRL = op_t'(6'b000010);

    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        GET_OP,
        EXEC,
        SEND
    } state_t;

    state_t              state_q;
    logic [NB_DATA-1:0]  dato_a_q;
    logic [NB_DATA-1:0]  dato_b_q;
    op_t                 op_q;
    logic [NB_DATA-1:0]  tx_data_q;
    logic                tx_valid_q;
    logic                busy_q;
    logic                error_q;

    op_t  rx_op;
    logic op_legal;

    assign rx_op = i_rx_data[NB_OPERADOR-1:0];

    always_comb begin
        op_legal = 1'b0;
        case (rx_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: op_legal = 1'b1;
            default:                        op_legal = 1'b0;
        endcase
    end

    // Words arriving in EXEC/SEND fall through untouched: there is no rx ready.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= GET_A;
            dato_a_q   <= '0;
            dato_b_q   <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            error_q <= 1'b0;
            unique case (state_q)
                GET_A: begin
                    if (i_rx_valid) begin
                        dato_a_q <= i_rx_data;
                        state_q  <= GET_B;
                    end
                end
                GET_B: begin
                    if (i_rx_valid) begin
                        dato_b_q <= i_rx_data;
                        state_q  <= GET_OP;
                    end
                end
                GET_OP: begin
                    if (i_rx_valid) begin
                        if (op_legal) begin
                            op_q    <= rx_op;
                            busy_q  <= 1'b1;
                            state_q <= EXEC;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= GET_A;
                        end
                    end
                end
                EXEC: begin
                    tx_data_q  <= i_resultado;
                    tx_valid_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: begin
                    if (i_tx_ready) begin
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= GET_A;
                    end
                end
                default: state_q <= GET_A;
            endcase
        end
    end

    assign o_dato_a   = dato_a_q;
    assign o_dato_b   = dato_b_q;
    assign o_operador = op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_busy     = busy_q;
    assign o_error    = error_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU attached
// to its operand/opcode outputs.
module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] dato_a;
    logic [7:0] dato_b;
    logic [5:0] operador;
    logic [7:0] resultado;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       error;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];

    alu_cmd_sequencer #(
        .NB_DATA    (8),
        .NB_OPERADOR(6)
    ) dut (
        .i_clock    (clk),
        .i_reset_n  (rst_n),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_dato_a   (dato_a),
        .o_dato_b   (dato_b),
        .o_operador (operador),
        .i_resultado(resultado),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_busy     (busy),
        .o_error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        resultado = 8'h00;
        case (operador)
            6'b100000: resultado = dato_a + dato_b;
            6'b100010: resultado = dato_a - dato_b;
            6'b100100: resultado = dato_a & dato_b;
            6'b100101: resultado = dato_a | dato_b;
            6'b100110: resultado = dato_a ^ dato_b;
            6'b100111: resultado = ~(dato_a | dato_b);
            6'b000011: resultado = $unsigned($signed(dato_a) >>> dato_b);
            6'b000010: resultado = dato_a >> dato_b;
            default:   resultado = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    logic       prev_hold;
    logic [7:0] prev_data;
    initial prev_hold = 1'b0;

    always @(negedge clk) begin
        if (rst_n && tx_valid) begin
            if (prev_hold) chk("tx_hold", tx_data, prev_data);
            if (tx_ready) begin
                if (exp_q.size() == 0) chk("tx_unexpected", 1, 0);
                else chk("tx_data", tx_data, exp_q.pop_front());
            end
        end
        prev_hold = rst_n && tx_valid && !tx_ready;
        prev_data = tx_data;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input logic [7:0] w);
        rx_data  = w;
        rx_valid = 1'b1;
        step();
    endtask

    task automatic finish_txn(input logic [7:0] b, input logic [7:0] op,
                              input logic [7:0] exp);
        put(b);
        exp_q.push_back(exp);
        put(op);
        rx_valid = 1'b0;
        chk("exec_busy", busy, 1);
        chk("exec_valid", tx_valid, 0);
        step();
        chk("send_valid", tx_valid, 1);
        step();
        chk("done_valid", tx_valid, 0);
        chk("done_busy", busy, 0);
    endtask

    task automatic txn(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] op, input logic [7:0] exp);
        put(a);
        finish_txn(b, op, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a"}, dato_a, 0);
        chk({tag, "_b"}, dato_b, 0);
        chk({tag, "_op"}, operador, 0);
        chk({tag, "_txd"}, tx_data, 0);
        chk({tag, "_txv"}, tx_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, error, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        step();
        step();
        chk_all_zero("rst");
        rst_n = 1'b1;
        step();

        txn(8'h05, 8'h0A, 8'h20, 8'h0F);
        chk("add_op", operador, 6'b100000);
        txn(8'h06, 8'h07, 8'h22, 8'hFF);
        txn(8'h96, 8'h03, 8'h03, 8'hF2);

        tx_ready = 1'b0;
        put(8'h15);
        put(8'h07);
        exp_q.push_back(8'h05);
        put(8'h24);
        rx_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", tx_valid, 1);
            chk("bp_data", tx_data, 8'h05);
            rx_valid = (i == 1) || (i == 2);
            rx_data  = (i == 1) ? 8'h11 : 8'h22;
            step();
        end
        rx_valid = 1'b0;
        chk("bp_keep_a", dato_a, 8'h15);
        chk("bp_keep_b", dato_b, 8'h07);
        tx_ready = 1'b1;
        rx_data  = 8'h33;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        chk("hs_valid", tx_valid, 0);
        chk("hs_drop_a", dato_a, 8'h15);
        txn(8'h0C, 8'h03, 8'h25, 8'h0F);

        put(8'h01);
        put(8'h02);
        put(8'h21);
        chk("ill_err", error, 1);
        chk("ill_valid", tx_valid, 0);
        chk("ill_busy", busy, 0);
        chk("ill_op", operador, 6'b100101);
        put(8'h03);
        chk("ill_err_end", error, 0);
        chk("ill_next_a", dato_a, 8'h03);
        finish_txn(8'h04, 8'h25, 8'h07);

        put(8'h55);
        put(8'h66);
        rx_valid = 1'b0;
        chk("mid_b", dato_b, 8'h66);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("mid_rst");
        step();
        rst_n = 1'b1;
        step();
        txn(8'h01, 8'h01, 8'h20, 8'h02);

        step();
        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
